// File: rtl/csa_pkg.sv
// csa_pkg: step codes, FSM encoding and sizing helpers shared by the csa_ram loader.
package csa_pkg;
    localparam int CSA_STEP_REQ  = 0;
    localparam int CSA_STEP_DATA = 1;
    localparam int CSA_STEP_FIN  = 2;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_REQ    = 4'd1;
    localparam logic [3:0] S_STUFF  = 4'd2;
    localparam logic [3:0] S_FIN    = 4'd3;
    localparam logic [3:0] S_WAIT   = 4'd4;
    localparam logic [3:0] S_CAPT   = 4'd5;
    localparam logic [3:0] S_OUT    = 4'd6;
    localparam logic [3:0] S_SETTLE = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    // 5 packed input bytes per item, rounded up to whole 32-bit words
    function automatic int words_of(input int items);
        return (items * 5 + 3) / 4;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/csa_load_ctrl_if.sv
// csa_load_ctrl_if: control, input stream, csa_ram write/read and output stream of the loader.
interface csa_load_ctrl_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int OPT_MEM_ADDR_BITS  = 3
);
    logic                              start, abort, busy, done, err;
    logic                              in_valid, in_ready;
    logic [C_S_AXI_DATA_WIDTH-1:0]     in_data;
    logic                              ram_wen;
    logic [OPT_MEM_ADDR_BITS:0]        ram_waddr;
    logic [C_S_AXI_DATA_WIDTH-1:0]     ram_wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   ram_wstrb;
    logic                              ram_ready, ram_adv;
    logic [47:0]                       ram_byte_out;
    logic                              out_valid, out_ready, out_last;
    logic [47:0]                       out_data;

    modport slave (
        input  start, abort, in_valid, in_data, ram_ready, ram_byte_out, out_ready,
        output busy, done, err, in_ready, ram_wen, ram_waddr, ram_wdata, ram_wstrb, ram_adv,
               out_valid, out_data, out_last
    );
    modport master (
        output start, abort, in_valid, in_data, ram_ready, ram_byte_out, out_ready,
        input  busy, done, err, in_ready, ram_wen, ram_waddr, ram_wdata, ram_wstrb, ram_adv,
               out_valid, out_data, out_last
    );
endinterface

// File: rtl/csa_timeout_cnt.sv
// csa_timeout_cnt: loadable up-counter that stops and flags expiry at LIMIT-1.
module csa_timeout_cnt #(
    parameter int LIMIT = 1024,
    parameter int W     = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_value,
    output logic         o_expired
);
    logic [W-1:0] r_cnt;

    assign o_expired = r_cnt == W'(LIMIT - 1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                r_cnt <= '0;
        else if (i_load)             r_cnt <= i_value;
        else if (i_en && !o_expired) r_cnt <= r_cnt + W'(1);
    end
endmodule

// File: rtl/csa_load_ctrl.sv
// csa_load_ctrl: drives the csa_ram stuffing protocol from an input word stream,
// then drains the per-item 48-bit results onto an output stream.
module csa_load_ctrl
    import csa_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int OPT_MEM_ADDR_BITS  = 3,
    parameter int CAL_DATA_ITEM_NUM  = 4,
    parameter int STEP_REQ_STUFF     = CSA_STEP_REQ,
    parameter int STEP_STUFFING_DATA = CSA_STEP_DATA,
    parameter int STEP_FIN_STUFF     = CSA_STEP_FIN,
    parameter int READY_TIMEOUT      = 1024
) (
    input logic              S_AXI_ACLK,
    input logic              S_AXI_ARESETN,
    csa_load_ctrl_if.slave   bus
);
    localparam int WORDS = words_of(CAL_DATA_ITEM_NUM);
    localparam int WW    = cnt_w(WORDS);
    localparam int IW    = cnt_w(CAL_DATA_ITEM_NUM);
    localparam int TW    = cnt_w(READY_TIMEOUT);
    localparam int AW    = OPT_MEM_ADDR_BITS + 1;
    localparam int SW    = C_S_AXI_DATA_WIDTH / 8;

    logic [3:0]    r_state;
    logic [WW-1:0] r_wcnt;
    logic [IW-1:0] r_icnt;
    logic [47:0]   r_data;
    logic          r_err;
    logic          w_wait, w_in_hs, w_out_hs, w_last, w_expired;

    assign w_wait   = r_state == S_WAIT;
    assign w_in_hs  = r_state == S_STUFF && bus.in_valid;
    assign w_out_hs = r_state == S_OUT && bus.out_ready;
    assign w_last   = r_icnt == IW'(CAL_DATA_ITEM_NUM - 1);

    // held cleared outside WAIT_RDY so each wait starts counting from 0
    csa_timeout_cnt #(.LIMIT(READY_TIMEOUT), .W(TW)) u_timeout (
        .i_clk     (S_AXI_ACLK),
        .i_rst_n   (S_AXI_ARESETN),
        .i_load    (!w_wait),
        .i_en      (w_wait),
        .i_value   ('0),
        .o_expired (w_expired)
    );

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
            r_icnt  <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else if (bus.abort) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_state <= S_REQ;
                    r_err   <= 1'b0;
                    r_wcnt  <= '0;
                    r_icnt  <= '0;
                end
                S_REQ:   r_state <= S_STUFF;
                S_STUFF: if (w_in_hs) begin
                    r_wcnt <= r_wcnt + WW'(1);
                    if (r_wcnt == WW'(WORDS - 1)) r_state <= S_FIN;
                end
                S_FIN:   r_state <= S_WAIT;
                S_WAIT:  if (bus.ram_ready) r_state <= S_CAPT;
                         else if (w_expired) begin
                             r_err   <= 1'b1;
                             r_state <= S_DONE;
                         end
                S_CAPT: begin
                    r_data  <= bus.ram_byte_out;
                    r_state <= S_OUT;
                end
                S_OUT: if (bus.out_ready) begin
                    r_state <= w_last ? S_DONE : S_SETTLE;
                    if (!w_last) r_icnt <= r_icnt + IW'(1);
                end
                S_SETTLE: r_state <= S_CAPT;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_state != S_IDLE;
    assign bus.done      = r_state == S_DONE;
    assign bus.err       = r_err;
    assign bus.in_ready  = r_state == S_STUFF;
    // data words pass straight through to csa_ram in the handshake cycle
    assign bus.ram_wen   = r_state == S_REQ || r_state == S_FIN || w_in_hs;
    assign bus.ram_waddr = r_state == S_REQ ? AW'(STEP_REQ_STUFF) :
                           r_state == S_FIN ? AW'(STEP_FIN_STUFF) :
                           w_in_hs          ? AW'(STEP_STUFFING_DATA) : '0;
    assign bus.ram_wdata = w_in_hs ? bus.in_data : '0;
    assign bus.ram_wstrb = {SW{bus.ram_wen}};
    assign bus.ram_adv   = w_out_hs && !w_last;
    assign bus.out_valid = r_state == S_OUT;
    assign bus.out_data  = r_data;
    assign bus.out_last  = bus.out_valid && w_last;
endmodule

// File: tb/tb_csa_load_ctrl.sv
// tb_csa_load_ctrl: directed and randomized batches checked against a queue-based model
// of the csa_ram write sequence and the expected result stream.
module tb_csa_load_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csa_load_ctrl_if bus ();
    csa_load_ctrl #(.READY_TIMEOUT(16)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .bus           (bus)
    );

    int total = 0;
    int bad = 0;
    logic [35:0] wq[$];
    logic [48:0] oq[$];
    logic [31:0] words[5];
    logic [47:0] items[4];
    int cyc = 0;
    int w_idx, r_idx, gap_after, gap_len, gap_left, rdy_delay, stall_item, stall_left, o_idx;
    int n_adv, n_data, n_done, req_cyc, lastw_cyc, fin_cyc, last_hs_cyc, done_cyc;
    bit rnd, drive, prev_stall, busy_obs, err_obs, err_done, ov_obs, wen_obs, ir_obs;
    logic [47:0] prev_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit hs_in, adv, stalled;
        logic [35:0] ew;
        logic [48:0] eo;
        @(negedge clk);
        cyc++;
        hs_in = bus.in_valid && bus.in_ready;
        if (bus.ram_wen) begin
            if (wq.size() == 0) chk("write_unexpected", bus.ram_wen, 1'b0);
            else begin
                ew = wq.pop_front();
                chk("waddr", bus.ram_waddr, ew[35:32]);
                chk("wdata", bus.ram_wdata, ew[31:0]);
                chk("wstrb", bus.ram_wstrb, 4'hF);
                if (ew[35:32] == 4'd0) req_cyc = cyc;
                if (ew[35:32] == 4'd1) begin
                    n_data++;
                    lastw_cyc = cyc;
                    chk("data_write_on_hs", hs_in, 1'b1);
                end
                if (ew[35:32] == 4'd2) fin_cyc = cyc;
            end
        end else chk("wstrb_idle", bus.ram_wstrb, 4'h0);
        stalled = 1'b0;
        if (bus.out_valid && !bus.out_ready) begin
            stalled = 1'b1;
            if (prev_stall) chk("out_hold", bus.out_data, prev_data);
            chk("adv_during_stall", bus.ram_adv, 1'b0);
            if (o_idx == stall_item && stall_left > 0) stall_left--;
        end else if (bus.out_valid) begin
            if (oq.size() == 0) chk("out_unexpected", bus.out_valid, 1'b0);
            else begin
                eo = oq.pop_front();
                chk("out_data", bus.out_data, eo[47:0]);
                chk("out_last", bus.out_last, eo[48]);
                chk("adv_on_hs", bus.ram_adv, !eo[48]);
                o_idx++;
                last_hs_cyc = cyc;
            end
        end else begin
            chk("adv_idle", bus.ram_adv, 1'b0);
            chk("last_idle", bus.out_last, 1'b0);
        end
        prev_stall = stalled;
        prev_data = bus.out_data;
        adv = bus.ram_adv;
        n_adv += int'(adv);
        if (bus.done) begin
            n_done++;
            done_cyc = cyc;
            err_done = bus.err;
        end
        busy_obs = bus.busy;
        err_obs = bus.err;
        ov_obs = bus.out_valid;
        wen_obs = bus.ram_wen;
        ir_obs = bus.in_ready;
        @(posedge clk);
        #1;
        if (hs_in) begin
            w_idx++;
            if (w_idx == gap_after) gap_left = gap_len;
        end
        if (adv && r_idx < 3) r_idx++;
        bus.ram_byte_out = items[r_idx];
        if (gap_left > 0) begin
            bus.in_valid = 1'b0;
            gap_left--;
        end else bus.in_valid = drive && w_idx < 5 && (!rnd || $urandom_range(0, 3) != 0);
        bus.in_data = words[w_idx < 5 ? w_idx : 0];
        bus.ram_ready = fin_cyc > 0 && rdy_delay >= 0 && cyc + 1 - fin_cyc >= rdy_delay;
        bus.out_ready = !(o_idx == stall_item && stall_left > 0) && (!rnd || $urandom_range(0, 2) != 0);
    endtask

    task automatic setup(input int nw, input bit full_out, input int gaft, input int glen,
                         input int rdel, input int sitem, input int slen, input bit rmode);
        wq.delete();
        oq.delete();
        wq.push_back({4'd0, 32'd0});
        for (int i = 0; i < nw; i++) wq.push_back({4'd1, words[i]});
        if (nw == 5) wq.push_back({4'd2, 32'd0});
        if (full_out) for (int i = 0; i < 4; i++) oq.push_back({i == 3, items[i]});
        w_idx = 0; r_idx = 0; o_idx = 0; gap_left = 0;
        gap_after = gaft; gap_len = glen; rdy_delay = rdel;
        stall_item = sitem; stall_left = slen; rnd = rmode; drive = 1'b1;
        n_adv = 0; n_data = 0; n_done = 0; req_cyc = 0; lastw_cyc = 0;
        fin_cyc = 0; last_hs_cyc = 0; done_cyc = 0; prev_stall = 1'b0;
        bus.ram_ready = 1'b0;
        bus.ram_byte_out = items[0];
        bus.in_data = words[0];
        bus.in_valid = 1'b1;
        bus.out_ready = !(sitem == 0 && slen > 0);
    endtask

    task automatic run_batch(input int gaft, input int glen, input int rdel,
                             input int sitem, input int slen, input bit rmode);
        int start_cyc;
        int n;
        setup(5, rdel >= 0, gaft, glen, rdel, sitem, slen, rmode);
        bus.start = 1'b1;
        start_cyc = cyc + 1;
        tick();
        bus.start = 1'b0;
        chk("busy_on_start", busy_obs, 1'b0);
        tick();
        chk("busy_after_start", busy_obs, 1'b1);
        chk("err_cleared", err_obs, 1'b0);
        n = 0;
        while (done_cyc == 0 && n < 400) begin
            tick();
            n++;
        end
        chk("done_seen", done_cyc != 0, 1'b1);
        tick();
        tick();
        chk("busy_after_done", busy_obs, 1'b0);
        chk("done_pulse_count", n_done, 1);
        chk("req_latency", req_cyc - start_cyc, 1);
        chk("data_writes", n_data, 5);
        chk("fin_after_last_word", fin_cyc - lastw_cyc, 1);
        chk("writes_left", wq.size(), 0);
        chk("outputs_left", oq.size(), 0);
        if (rdel >= 0) begin
            chk("done_after_last_hs", done_cyc - last_hs_cyc, 1);
            chk("adv_pulses", n_adv, 3);
            chk("err_ok", err_done, 1'b0);
        end else begin
            chk("timeout_latency", done_cyc - fin_cyc - 1, 16);
            chk("err_timeout", err_done, 1'b1);
            chk("adv_pulses_timeout", n_adv, 0);
        end
        fin_cyc = 0;
        bus.ram_ready = 1'b0;
    endtask

    initial begin
        int n;
        bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        bus.ram_ready = 1'b0; bus.ram_byte_out = '0; bus.out_ready = 1'b0;
        words = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 32'h13121110};
        items = '{48'h0000AABBCCDD, 48'h111111111111, 48'h222222222222, 48'h333333333333};
        stall_item = -1; gap_after = -1; rdy_delay = -1; drive = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_wen", bus.ram_wen, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 48'h0);
        rst_n = 1'b1;
        tick();

        run_batch(-1, 0, 10, -1, 0, 1'b0);
        run_batch(2, 3, 10, 1, 5, 1'b0);
        run_batch(-1, 0, -1, -1, 0, 1'b0);

        // abort together with start from IDLE: abort wins and err keeps its timeout value
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tick();
        chk("abort_beats_start", busy_obs, 1'b0);
        chk("abort_keeps_err", err_obs, 1'b1);

        setup(2, 1'b0, -1, 0, -1, -1, 0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (w_idx < 2 && n < 20) begin
            tick();
            n++;
        end
        chk("abort_words_taken", w_idx, 2);
        drive = 1'b0;
        bus.in_valid = 1'b0;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        tick();
        chk("abort_busy", busy_obs, 1'b0);
        chk("abort_wen", wen_obs, 1'b0);
        chk("abort_in_ready", ir_obs, 1'b0);
        repeat (5) tick();
        chk("abort_no_fin", fin_cyc, 0);
        chk("abort_writes_left", wq.size(), 0);
        chk("abort_err", err_obs, 1'b0);

        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 5; i++) words[i] = $urandom;
            for (int i = 0; i < 4; i++) items[i] = {16'($urandom), 32'($urandom)};
            run_batch(-1, 0, int'($urandom_range(0, 14)), -1, 0, 1'b1);
        end

        items[0] = 48'hDEADBEEF0001;
        setup(5, 1'b1, -1, 0, 2, 0, 1000, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (!ov_obs && n < 60) begin
            tick();
            n++;
        end
        chk("reached_out", ov_obs, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_done", bus.done, 1'b0);
        chk("arst_in_ready", bus.in_ready, 1'b0);
        chk("arst_wen", bus.ram_wen, 1'b0);
        chk("arst_waddr", bus.ram_waddr, 4'h0);
        chk("arst_wdata", bus.ram_wdata, 32'h0);
        chk("arst_wstrb", bus.ram_wstrb, 4'h0);
        chk("arst_adv", bus.ram_adv, 1'b0);
        chk("arst_out_valid", bus.out_valid, 1'b0);
        chk("arst_out_data", bus.out_data, 48'h0);
        chk("arst_out_last", bus.out_last, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) words[i] = $urandom;
        for (int i = 0; i < 4; i++) items[i] = {16'($urandom), 32'($urandom)};
        run_batch(1, 2, int'($urandom_range(0, 14)), 3, 4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/csa_load_ctrl.md
Name: csa_load_ctrl

Overview:
- Sequencer that loads and drains csa_ram for one batch of CAL_DATA_ITEM_NUM items.
- Takes 32-bit packed input words from a valid/ready stream and issues the csa_ram write protocol: STEP_REQ_STUFF, then the STEP_STUFFING_DATA words, then STEP_FIN_STUFF.
- Waits for csa_ram ready, then streams the 48-bit per-item results (6 bytes each) out on a valid/ready stream.
- Sits between the AXI-lite register slave / DMA word source and csa_ram, replacing the software-driven step writes.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, width of the input word and ram_wdata; only 32 supported.
- OPT_MEM_ADDR_BITS, 3, ram_waddr is [OPT_MEM_ADDR_BITS:0].
- CAL_DATA_ITEM_NUM, 4, items per batch; 5 input bytes per item, 6 output bytes per item.
- STEP_REQ_STUFF, 0, ram_waddr value for the request step.
- STEP_STUFFING_DATA, 1, ram_waddr value for data words.
- STEP_FIN_STUFF, 2, ram_waddr value for the finish step.
- READY_TIMEOUT, 1024, maximum cycles spent in WAIT_RDY before an error.

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a batch when idle
- abort  in  1  synchronous; returns to IDLE from any state
- busy  out  1  high from the cycle after an accepted start until DONE is left
- done  out  1  one-cycle pulse at batch end
- err  out  1  sticky timeout flag; cleared by the next accepted start
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid && in_ready
- in_data  in  32  packed item bytes, little-endian
- ram_wen  out  1  csa_ram write enable
- ram_waddr  out  OPT_MEM_ADDR_BITS+1  step code
- ram_wdata  out  32  write data
- ram_wstrb  out  4  always 4'hF while ram_wen, else 0
- ram_ready  in  1  csa_ram results valid
- ram_byte_out  in  48  current item result, byte0 = [7:0]
- ram_adv  out  1  one-cycle pulse; csa_ram presents the next item on the following cycle
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  48  result item
- out_last  out  1  high with the final item of the batch

Behaviour:
- WORDS = ceil(CAL_DATA_ITEM_NUM*5/4), which is 5 at the default. Word counter and item counter are each clog2 wide (minimum 1 bit).
- Reset values: all outputs 0; state IDLE; counters 0; err 0.
- IDLE:
  - start goes to REQ and clears err.
  - start while not IDLE is ignored.
- REQ: one cycle with ram_wen=1, ram_waddr=STEP_REQ_STUFF, ram_wdata=0; then STUFF.
- STUFF:
  - in_ready=1.
  - Each handshake drives, in that same cycle, ram_wen=1, ram_waddr=STEP_STUFFING_DATA, ram_wdata=in_data (combinational pass-through, no buffering).
  - No handshake means ram_wen=0.
  - After the WORDS-th handshake, go to FIN. Extra input words are not accepted (in_ready=0 outside STUFF).
- FIN: one cycle with ram_wen=1, ram_waddr=STEP_FIN_STUFF, ram_wdata=0; then WAIT_RDY with the timeout counter at 0.
- WAIT_RDY:
  - ram_ready sampled high goes to CAPT.
  - Counter reaching READY_TIMEOUT-1 sets err and goes to DONE.
- CAPT: register ram_byte_out into out_data, set out_valid=1, go to OUT.
- OUT:
  - Hold out_data and out_valid stable until out_ready.
  - out_last=1 when item counter == CAL_DATA_ITEM_NUM-1.
  - On handshake, clear out_valid.
  - If not last: pulse ram_adv, increment the item counter, go to SETTLE.
  - If last: go to DONE.
- SETTLE: one idle cycle, then CAPT. Each item therefore costs at least 3 cycles.
- DONE: done=1 for one cycle, busy drops, go to IDLE.
- abort: on the next edge go to IDLE and clear out_valid, ram_wen and ram_adv. No FIN is issued; err is unchanged. abort wins over start in the same cycle.
- ram_ready dropping during CAPT/OUT/SETTLE is ignored; data is captured regardless.
- Asynchronous reset mid-batch: immediate return to reset values. csa_ram is expected to restart from a new REQ.

Decomposition:
- Shared package csa_pkg: the three STEP codes, state enum encoding, and a localparam function for WORDS.
- One sub-module, csa_timeout_cnt: a loadable up-counter with an expiry flag, reusable for other ready waits. The FSM stays in csa_load_ctrl.

Test Plan:
- Default params, in_data words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, 0x13121110 with in_valid always high -> ram_waddr sequence 0,1,1,1,1,1,2 with ram_wen high on each; ram_wdata matches each word in order; REQ occurs 1 cycle after start.
- in_valid deasserted for 3 cycles after word 2 -> ram_wen low during the gap; only 5 data writes total; FIN follows word 5 by exactly 1 cycle.
- ram_ready asserted 10 cycles after FIN with ram_byte_out sequence 0x0000AABBCCDD, 0x111111111111, 0x222222222222, 0x333333333333 (advanced on ram_adv), out_ready high -> 4 outputs in order; out_last only on 0x333333333333; 3 ram_adv pulses; done 1 cycle after the last handshake.
- out_ready low for 5 cycles on item 1 -> out_data stable, no ram_adv until the handshake.
- ram_ready never asserted, READY_TIMEOUT=16 -> err=1 and done pulse exactly 16 cycles after entering WAIT_RDY; next start clears err.
- abort during STUFF after 2 words, then S_AXI_ARESETN low mid-OUT -> IDLE with ram_wen=0 next cycle; all outputs 0 immediately on reset without a clock edge.
